// File: rtl/pc_branch_seq_if.sv
// Bus bundle for the conditional-branch PC sequencer.
// master: the controller that issues requests and owns the CON stage.
// slave:  the sequencer itself.
interface pc_branch_seq_if #(
    parameter int BITS = 32
) ();

    // Requests into the sequencer
    logic            start;
    logic [BITS-1:0] ir;
    logic            con_in;
    logic            pc_load;
    logic [BITS-1:0] pc_in;
    logic            incpc;

    // Results from the sequencer
    logic            con_enable;
    logic [1:0]      ir_c2;
    logic [BITS-1:0] pc;
    logic            busy;
    logic            done;
    logic            taken;
    logic [15:0]     taken_count;

    modport master (
        output start, ir, con_in, pc_load, pc_in, incpc,
        input  con_enable, ir_c2, pc, busy, done, taken, taken_count
    );

    modport slave (
        input  start, ir, con_in, pc_load, pc_in, incpc,
        output con_enable, ir_c2, pc, busy, done, taken, taken_count
    );

endinterface

// File: rtl/pc_branch_seq.sv
// Conditional-branch program-counter sequencer.
// A branch walks IDLE -> EVAL -> UPDATE -> FIN. EVAL asks the external CON
// stage for the condition, UPDATE applies the sign-extended 19-bit offset
// when the condition holds, and FIN pulses done. While idle, the PC can be
// loaded or incremented; a start in the same cycle sees the updated PC.
module pc_branch_seq #(
    parameter int BITS = 32
) (
    input  logic             clk,
    input  logic             clr,
    pc_branch_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    // Sign-extend the 19-bit branch offset to the PC width.
    function automatic logic [BITS-1:0] sext_offset(input logic [18:0] off);
        return {{(BITS-19){off[18]}}, off};
    endfunction

    // Saturating increment for the taken-branch counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] res;
        if (v == 16'hFFFF) begin
            res = v;
        end else begin
            res = v + 16'd1;
        end
        return res;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;

    logic [BITS-1:0] r_pc;
    logic [1:0]      r_ir_c2;
    logic [18:0]     r_offset;
    logic            r_con_q;
    logic            r_taken;
    logic [15:0]     r_taken_count;

    logic [BITS-1:0] w_pc_nxt;
    logic [1:0]      w_ir_c2_nxt;
    logic [18:0]     w_offset_nxt;
    logic            w_con_q_nxt;
    logic            w_taken_nxt;
    logic [15:0]     w_taken_count_nxt;

    logic            w_con_enable;
    logic            w_busy;
    logic            w_done;

    // State register; clr drops any in-flight branch back to idle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_con_enable = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = ST_EVAL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EVAL: begin
                w_con_enable = 1'b1;
                w_state_nxt  = ST_UPDATE;
            end
            ST_UPDATE: begin
                w_state_nxt = ST_FIN;
            end
            ST_FIN: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath next values; every register holds unless its state acts on it.
    always_comb begin
        w_pc_nxt          = r_pc;
        w_ir_c2_nxt       = r_ir_c2;
        w_offset_nxt      = r_offset;
        w_con_q_nxt       = r_con_q;
        w_taken_nxt       = r_taken;
        w_taken_count_nxt = r_taken_count;
        case (r_state)
            ST_IDLE: begin
                // Load wins over increment; increment wraps naturally.
                if (bus.pc_load) begin
                    w_pc_nxt = bus.pc_in;
                end else if (bus.incpc) begin
                    w_pc_nxt = r_pc + BITS'(1);
                end else begin
                    w_pc_nxt = r_pc;
                end
                // Capture the branch fields; the offset is applied later
                // to whatever PC this same edge produces.
                if (bus.start) begin
                    w_ir_c2_nxt  = bus.ir[20:19];
                    w_offset_nxt = bus.ir[18:0];
                end else begin
                    w_ir_c2_nxt  = r_ir_c2;
                    w_offset_nxt = r_offset;
                end
            end
            ST_EVAL: begin
                w_con_q_nxt = bus.con_in;
            end
            ST_UPDATE: begin
                if (r_con_q) begin
                    w_pc_nxt          = r_pc + sext_offset(r_offset);
                    w_taken_nxt       = 1'b1;
                    w_taken_count_nxt = sat_inc16(r_taken_count);
                end else begin
                    w_pc_nxt          = r_pc;
                    w_taken_nxt       = 1'b0;
                    w_taken_count_nxt = r_taken_count;
                end
            end
            ST_FIN: begin
                w_pc_nxt = r_pc;
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
    end

    // Datapath registers, cleared asynchronously by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pc          <= '0;
            r_ir_c2       <= 2'b00;
            r_offset      <= 19'd0;
            r_con_q       <= 1'b0;
            r_taken       <= 1'b0;
            r_taken_count <= 16'd0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_ir_c2       <= w_ir_c2_nxt;
            r_offset      <= w_offset_nxt;
            r_con_q       <= w_con_q_nxt;
            r_taken       <= w_taken_nxt;
            r_taken_count <= w_taken_count_nxt;
        end
    end

    assign bus.con_enable  = w_con_enable;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.ir_c2       = r_ir_c2;
    assign bus.pc          = r_pc;
    assign bus.taken       = r_taken;
    assign bus.taken_count = r_taken_count;

endmodule

// File: tb/tb_pc_branch_seq.sv
// Directed bench for pc_branch_seq: PC load/increment, taken / not-taken
// branches with cycle-exact handshake, ignore-while-busy, mid-branch clear
// and counter saturation.
module tb_pc_branch_seq;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;

    pc_branch_seq_if #(.BITS(32)) bus ();

    pc_branch_seq #(.BITS(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One-cycle PC control pulse, issued from a falling edge in IDLE.
    task automatic pulse_pc(input logic ld, input logic inc, input logic [31:0] pin);
        bus.pc_load = ld;
        bus.incpc   = inc;
        bus.pc_in   = pin;
        @(negedge clk);
        bus.pc_load = 1'b0;
        bus.incpc   = 1'b0;
    endtask

    // Full branch with cycle-by-cycle checks. noise drives start/pc_load/incpc
    // and a different ir while the branch is busy.
    task automatic do_branch(input logic [1:0] c2, input logic [18:0] off, input logic con,
                             input logic inc, input logic noise,
                             input logic [31:0] exp_pc, input logic [15:0] exp_cnt);
        logic [1:0] c2_other;
        c2_other    = ~c2;
        bus.start   = 1'b1;
        bus.ir      = {11'd0, c2, off};
        bus.incpc   = inc;
        bus.con_in  = 1'b0;
        @(negedge clk);                       // cycle N+1: EVAL
        bus.start   = 1'b0;
        bus.incpc   = 1'b0;
        bus.con_in  = con;
        check_eq("eval_con_enable", {63'd0, bus.con_enable}, 64'd1);
        check_eq("eval_busy", {63'd0, bus.busy}, 64'd1);
        check_eq("eval_ir_c2", {62'd0, bus.ir_c2}, {62'd0, c2});
        check_eq("eval_done", {63'd0, bus.done}, 64'd0);
        if (noise) begin
            bus.start   = 1'b1;
            bus.pc_load = 1'b1;
            bus.pc_in   = 32'h0000_0999;
            bus.incpc   = 1'b1;
            bus.ir      = {11'd0, c2_other, 19'h00100};
        end
        @(negedge clk);                       // cycle N+2: UPDATE
        check_eq("upd_con_enable", {63'd0, bus.con_enable}, 64'd0);
        check_eq("upd_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);                       // cycle N+3: FIN
        check_eq("fin_done", {63'd0, bus.done}, 64'd1);
        check_eq("fin_pc", {32'd0, bus.pc}, {32'd0, exp_pc});
        check_eq("fin_taken", {63'd0, bus.taken}, {63'd0, con});
        check_eq("fin_count", {48'd0, bus.taken_count}, {48'd0, exp_cnt});
        check_eq("fin_busy", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);                       // back in IDLE
        bus.start   = 1'b0;
        bus.pc_load = 1'b0;
        bus.incpc   = 1'b0;
        check_eq("idle_done", {63'd0, bus.done}, 64'd0);
        check_eq("idle_busy", {63'd0, bus.busy}, 64'd0);
        check_eq("idle_ir_c2", {62'd0, bus.ir_c2}, {62'd0, c2});
        check_eq("idle_pc", {32'd0, bus.pc}, {32'd0, exp_pc});
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        clr         = 1'b1;
        bus.start   = 1'b0;
        bus.ir      = 32'd0;
        bus.con_in  = 1'b0;
        bus.pc_load = 1'b0;
        bus.pc_in   = 32'd0;
        bus.incpc   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_pc", {32'd0, bus.pc}, 64'd0);
        check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
        check_eq("rst_done", {63'd0, bus.done}, 64'd0);
        check_eq("rst_con_enable", {63'd0, bus.con_enable}, 64'd0);
        check_eq("rst_ir_c2", {62'd0, bus.ir_c2}, 64'd0);
        check_eq("rst_taken", {63'd0, bus.taken}, 64'd0);
        check_eq("rst_count", {48'd0, bus.taken_count}, 64'd0);
        clr = 1'b0;

        // Taken forward branch from 0x10, offset +5
        pulse_pc(1'b1, 1'b0, 32'h0000_0010);
        check_eq("load_pc", {32'd0, bus.pc}, 64'h10);
        do_branch(2'b00, 19'h00005, 1'b1, 1'b0, 1'b0, 32'h0000_0015, 16'd1);

        // Not-taken branch leaves pc and count
        pulse_pc(1'b1, 1'b0, 32'h0000_0010);
        do_branch(2'b10, 19'h00005, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 16'd1);
        @(negedge clk);
        check_eq("nt_single_done", {63'd0, bus.done}, 64'd0);

        // Negative offset wraps below zero
        pulse_pc(1'b1, 1'b0, 32'h0000_0002);
        do_branch(2'b01, 19'h7FFFC, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 16'd2);

        // Increment wraps all-ones to zero, then counts up
        pulse_pc(1'b1, 1'b0, 32'hFFFF_FFFF);
        pulse_pc(1'b0, 1'b1, 32'd0);
        check_eq("inc_wrap", {32'd0, bus.pc}, 64'd0);
        pulse_pc(1'b0, 1'b1, 32'd0);
        check_eq("inc_one", {32'd0, bus.pc}, 64'd1);

        // Load beats increment
        pulse_pc(1'b1, 1'b1, 32'h0000_0040);
        check_eq("load_prio", {32'd0, bus.pc}, 64'h40);

        // Start together with incpc: branch applies to 0x41
        do_branch(2'b11, 19'h00003, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 16'd3);

        // Requests while busy are ignored
        do_branch(2'b10, 19'h00001, 1'b1, 1'b0, 1'b1, 32'h0000_0045, 16'd4);

        // Clear during UPDATE abandons the branch
        bus.start  = 1'b1;
        bus.ir     = {11'd0, 2'b01, 19'h00010};
        @(negedge clk);
        bus.start  = 1'b0;
        bus.con_in = 1'b1;
        @(negedge clk);
        clr = 1'b1;
        #1;
        check_eq("clr_busy", {63'd0, bus.busy}, 64'd0);
        check_eq("clr_pc", {32'd0, bus.pc}, 64'd0);
        check_eq("clr_done", {63'd0, bus.done}, 64'd0);
        check_eq("clr_count", {48'd0, bus.taken_count}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("clr_no_done", {63'd0, bus.done}, 64'd0);
        end
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_clr_no_done", {63'd0, bus.done}, 64'd0);
        end
        check_eq("post_clr_pc", {32'd0, bus.pc}, 64'd0);
        do_branch(2'b01, 19'h00007, 1'b1, 1'b0, 1'b0, 32'h0000_0007, 16'd1);

        // Counter saturation: preset just below the ceiling
        force dut.r_taken_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_taken_count;
        check_eq("sat_preset", {48'd0, bus.taken_count}, 64'hFFFE);
        do_branch(2'b00, 19'h00001, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 16'hFFFF);
        do_branch(2'b00, 19'h00001, 1'b1, 1'b0, 1'b0, 32'h0000_0009, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
